fpu_sub_round_pack: RTL and testbench
=====================================

Name: fpu_sub_round_pack

Overview:
- Downstream consumer of the double-precision subtract pipeline's unrounded outputs: sign, 56-bit diff_2 and 11-bit exponent_2.
- Applies IEEE-754 rounding in one of four modes, renormalises on rounding carry, and packs a 64-bit double.
- Raises inexact, underflow and zero flags.
- Two-stage pipeline with valid/ready handshakes on both sides, so the FPU result path can stall.

Parameters:
- EXP_W, 11, exponent width; only the default is supported and verified.
- FRAC_W, 52, fraction width; diff width is FRAC_W+4; only the default is supported and verified.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat this cycle.
- sign  in  1  result sign from the subtract stage.
- diff_2  in  56  bit 55 is 0; bit 54 is the hidden bit; bits 53:2 are the fraction; bit 1 is guard; bit 0 is round/sticky.
- exponent_2  in  11  biased exponent; 0 means denormal or zero.
- round_mode  in  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward -inf.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- result  out  64  packed double.
- inexact  out  1  guard or sticky bit was set.
- underflow  out  1  result is tiny and inexact.
- zero  out  1  result is +0 or -0.
- busy  out  1  either pipeline stage holds a beat.

Behaviour:
- Reset (rst low, asynchronous): both stage valids cleared; result, all flags and busy are 0. in_ready is 1 once reset is released.
- Reset asserted mid-operation discards any in-flight beats; out_valid falls without waiting for a clock edge.
- A beat is accepted when in_valid and in_ready are both high.
- Pipeline timing:
  - Stage 1 registers the round decision and the sum.
  - Stage 2 registers the packed result and flags.
  - out_valid rises 2 cycles after acceptance when there is no stall.
  - Throughput is 1 beat per cycle.
- Handshake rules:
  - s2 loads when !s2_valid or out_ready.
  - s1 advances when s1 is valid and s2 loads.
  - in_ready = !s1_valid or s1 advances (combinational from out_ready).
  - Beats are never dropped, duplicated or reordered.
  - Output data and flags hold stable while out_valid is high and out_ready is low.
- Round decision (g = diff_2[1], s = diff_2[0], lsb = diff_2[2]):
  - Nearest-even: round up when g & (s | lsb).
  - Toward zero: never round up.
  - Toward +inf: round up when !sign & (g | s).
  - Toward -inf: round up when sign & (g | s).
- Sum: rnd[53:0] = diff_2[55:2] + round_up, computed 54 bits wide.
- Normalisation, applied in priority order:
  - rnd[53]=1: fraction = rnd[52:1], exponent = exponent_2 + 1.
  - Else exponent_2 = 0 and rnd[52] = 1 (denormal rounds up to normal): exponent = 1, fraction = rnd[51:0].
  - Otherwise: exponent = exponent_2, fraction = rnd[51:0].
- Overflow: if the resulting exponent reaches 2047, the fraction is forced to 0 (infinity). Unreachable for finite subtraction; kept for robustness.
- Exact zero: diff_2 = 0 gives result 0x0000000000000000, except in toward -inf mode, which gives 0x8000000000000000. The sign input is ignored; zero = 1 and inexact = 0.
- Flags:
  - inexact = g | s.
  - underflow = inexact & (final exponent = 0). Tininess is detected after rounding.
  - zero = final exponent 0 and fraction 0.
- Packing: result = {sign, exponent, fraction}, except for the exact-zero sign rule above.
- round_mode is sampled with the beat; a change while a beat is stalled does not affect it.

Decomposition:
- Shared package fpu_pkg holds:
  - round-mode constants RM_NEAREST, RM_ZERO, RM_POS_INF, RM_NEG_INF;
  - EXP_MAX = 11'h7FF;
  - POS_ZERO and NEG_ZERO 64-bit constants;
  - a struct for the stage-1 payload.
- One combinational sub-module, fpu_round_decide (inputs sign, g, s, lsb, mode; output round_up), reused later by the mul and div round paths.

Test Plan:
1. Nearest-even, sign 0, exp 0x3FF, diff_2 56'h40000000000000 -> result 64'h3FF0000000000000, inexact 0, out_valid 2 cycles after accept.
2. Ties under nearest-even:
   - diff_2 56'h40000000000002, exp 0x3FF -> 64'h3FF0000000000000, inexact 1 (tie, even kept).
   - diff_2 56'h40000000000006 -> 64'h3FF0000000000002.
3. Rounding carry: nearest-even, exp 0x3FE, diff_2 56'h7FFFFFFFFFFFFE -> 64'h3FF0000000000000, inexact 1.
4. Denormal to normal: toward +inf, sign 0, exp 0, diff_2 56'h3FFFFFFFFFFFFF -> 64'h0010000000000000, inexact 1, underflow 0.
5. Exact zero, diff_2 0, exp 0, sign 1:
   - nearest-even -> 64'h0, zero 1.
   - toward -inf -> 64'h8000000000000000, zero 1.
6. Backpressure: out_ready low, 3 back-to-back beats -> in_ready low after 2 accepts; raise out_ready -> 3 results in order, none lost. Pull rst low mid-stream -> out_valid 0 before the next clock edge.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the double-precision round/pack paths: rounding-mode
// encodings, the all-ones exponent, signed-zero encodings and the stage-1 payload.
package fpu_pkg;

  localparam logic [1:0] RM_NEAREST = 2'b00;
  localparam logic [1:0] RM_ZERO    = 2'b01;
  localparam logic [1:0] RM_POS_INF = 2'b10;
  localparam logic [1:0] RM_NEG_INF = 2'b11;

  localparam logic [10:0] EXP_MAX = 11'h7FF;

  localparam logic [63:0] POS_ZERO = 64'h0000_0000_0000_0000;
  localparam logic [63:0] NEG_ZERO = 64'h8000_0000_0000_0000;

  // Round decision already folded into rnd; neg_zero remembers the mode for the exact-zero sign.
  typedef struct packed {
    logic        sign;
    logic        neg_zero;
    logic        exact_zero;
    logic        inexact;
    logic [10:0] exp;
    logic [53:0] rnd;
  } s1_payload_t;

endpackage

// File: rtl/fpu_round_decide.sv
// IEEE-754 round-up decision from sign, guard, sticky and result LSB.
// Shared by the sub, mul and div round paths.
module fpu_round_decide
  import fpu_pkg::*;
(
  input  logic       sign,
  input  logic       g,
  input  logic       s,
  input  logic       lsb,
  input  logic [1:0] mode,
  output logic       round_up
);

  always_comb begin
    round_up = 1'b0;
    case (mode)
      RM_NEAREST: round_up = g & (s | lsb);
      RM_ZERO:    round_up = 1'b0;
      RM_POS_INF: round_up = ~sign & (g | s);
      RM_NEG_INF: round_up = sign & (g | s);
      default:    round_up = 1'b0;
    endcase
  end

endmodule

// File: rtl/fpu_sub_round_pack.sv
// Rounds, renormalises and packs the subtract pipeline's unrounded result into a
// double, through a two-stage valid/ready pipeline that can stall on out_ready.
module fpu_sub_round_pack #(
  parameter int EXP_W  = 11,
  parameter int FRAC_W = 52
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    sign,
  input  logic [FRAC_W+3:0]       diff_2,
  input  logic [EXP_W-1:0]        exponent_2,
  input  logic [1:0]              round_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+FRAC_W:0]   result,
  output logic                    inexact,
  output logic                    underflow,
  output logic                    zero,
  output logic                    busy
);

  import fpu_pkg::*;

  logic        round_up;
  logic        s2_load;
  logic        s1_adv;
  logic        accept;
  logic        s1_valid_q, s1_valid_d;
  logic        s2_valid_q, s2_valid_d;
  s1_payload_t s1_q, s1_d, s1_in;
  logic [63:0] result_q, result_d;
  logic        inexact_q, inexact_d;
  logic        underflow_q, underflow_d;
  logic        zero_q, zero_d;
  logic [10:0] exp_n;
  logic [51:0] frac_n;

  fpu_round_decide u_round_decide (
    .sign     (sign),
    .g        (diff_2[1]),
    .s        (diff_2[0]),
    .lsb      (diff_2[2]),
    .mode     (round_mode),
    .round_up (round_up)
  );

  always_comb begin
    s1_in            = '0;
    s1_in.sign       = sign;
    s1_in.neg_zero   = (round_mode == RM_NEG_INF);
    s1_in.exact_zero = (diff_2 == '0);
    s1_in.inexact    = diff_2[1] | diff_2[0];
    s1_in.exp        = exponent_2;
    s1_in.rnd        = diff_2[55:2] + {53'd0, round_up};
  end

  // s2 drains or refills whenever it is empty or the consumer takes its beat.
  always_comb begin
    s2_load    = ~s2_valid_q | out_ready;
    s1_adv     = s1_valid_q & s2_load;
    in_ready   = ~s1_valid_q | s1_adv;
    accept     = in_valid & in_ready;
    s1_valid_d = accept | (s1_valid_q & ~s1_adv);
    s1_d       = accept ? s1_in : s1_q;
    s2_valid_d = s2_load ? s1_valid_q : s2_valid_q;
  end

  // Carry out of the hidden bit shifts right; a denormal that rounds into the hidden bit becomes normal.
  always_comb begin
    exp_n  = s1_q.exp;
    frac_n = s1_q.rnd[51:0];
    if (s1_q.rnd[53]) begin
      exp_n  = s1_q.exp + 11'd1;
      frac_n = s1_q.rnd[52:1];
    end else if ((s1_q.exp == 11'd0) && s1_q.rnd[52]) begin
      exp_n  = 11'd1;
    end
    if (exp_n == EXP_MAX) begin
      frac_n = '0;
    end
  end

  always_comb begin
    result_d    = result_q;
    inexact_d   = inexact_q;
    underflow_d = underflow_q;
    zero_d      = zero_q;
    if (s1_adv) begin
      if (s1_q.exact_zero) begin
        result_d    = s1_q.neg_zero ? NEG_ZERO : POS_ZERO;
        inexact_d   = 1'b0;
        underflow_d = 1'b0;
        zero_d      = 1'b1;
      end else begin
        result_d    = {s1_q.sign, exp_n, frac_n};
        inexact_d   = s1_q.inexact;
        underflow_d = s1_q.inexact & (exp_n == 11'd0);
        zero_d      = (exp_n == 11'd0) & (frac_n == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s1_q        <= '0;
      result_q    <= '0;
      inexact_q   <= 1'b0;
      underflow_q <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      s1_q        <= s1_d;
      result_q    <= result_d;
      inexact_q   <= inexact_d;
      underflow_q <= underflow_d;
      zero_q      <= zero_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign inexact   = inexact_q;
  assign underflow = underflow_q;
  assign zero      = zero_q;
  assign busy      = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_fpu_sub_round_pack.sv
// Table-driven, scoreboarded bench for fpu_sub_round_pack, plus hand sequences
// for latency, backpressure and asynchronous reset.
module tb_fpu_sub_round_pack;

  typedef struct packed {
    logic        sign;
    logic [1:0]  mode;
    logic [10:0] exp;
    logic [55:0] diff;
    logic [63:0] res;
    logic        inx;
    logic        unf;
    logic        zr;
  } vec_t;

  typedef struct packed {
    logic [63:0] res;
    logic        inx;
    logic        unf;
    logic        zr;
    logic [7:0]  id;
  } exp_t;

  localparam int NVEC = 17;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [55:0] diff_2;
  logic [10:0] exponent_2;
  logic [1:0]  round_mode;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        inexact;
  logic        underflow;
  logic        zero;
  logic        busy;

  vec_t vecs [NVEC];
  exp_t sb [$];
  exp_t cur_exp;
  exp_t mon_e;
  int   tests_run = 0;
  int   tests_failed = 0;
  int   n_out = 0;
  bit   rand_bp = 1'b0;

  fpu_sub_round_pack dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .sign       (sign),
    .diff_2     (diff_2),
    .exponent_2 (exponent_2),
    .round_mode (round_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .inexact    (inexact),
    .underflow  (underflow),
    .zero       (zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic s, input logic [1:0] m, input logic [10:0] e,
                              input logic [55:0] d, input logic [63:0] r,
                              input logic i, input logic u, input logic z);
    vec_t v;
    v.sign = s; v.mode = m; v.exp = e; v.diff = d;
    v.res = r; v.inx = i; v.unf = u; v.zr = z;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic checkBit(input string name, input logic got, input logic want);
    tests_run++;
    if (got !== want) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic applyStimulus(input vec_t v, input int id);
    bit done;
    sign       = v.sign;
    round_mode = v.mode;
    exponent_2 = v.exp;
    diff_2     = v.diff;
    cur_exp.res = v.res;
    cur_exp.inx = v.inx;
    cur_exp.unf = v.unf;
    cur_exp.zr  = v.zr;
    cur_exp.id  = 8'(id);
    in_valid   = 1'b1;
    done       = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL accept_timeout vec%0d: in_ready never 1, expected accept within 200 cycles", id);
    end
  endtask

  task automatic waitDrain(input string name);
    bit drained;
    drained = 1'b0;
    for (int i = 0; i < 300 && !drained; i++) begin
      if (sb.size() == 0 && !busy) drained = 1'b1;
      else @(negedge clk);
    end
    if (!drained) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL %s_drain: %0d results still pending, expected 0", name, sb.size());
    end
  endtask

  // Scoreboard: push on accept, pop and compare on each output transfer.
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_output: got %h, expected no result", result);
        end else begin
          mon_e = sb.pop_front();
          checkOutput($sformatf("vec%0d_result", mon_e.id), result, mon_e.res);
          checkBit($sformatf("vec%0d_inexact", mon_e.id), inexact, mon_e.inx);
          checkBit($sformatf("vec%0d_underflow", mon_e.id), underflow, mon_e.unf);
          checkBit($sformatf("vec%0d_zero", mon_e.id), zero, mon_e.zr);
        end
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    vecs[0]  = mk(1'b0, 2'b00, 11'h3FF, 56'h40000000000000, 64'h3FF0000000000000, 1'b0, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 2'b00, 11'h3FF, 56'h40000000000002, 64'h3FF0000000000000, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(1'b0, 2'b00, 11'h3FF, 56'h40000000000006, 64'h3FF0000000000002, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk(1'b0, 2'b00, 11'h3FE, 56'h7FFFFFFFFFFFFE, 64'h3FF0000000000000, 1'b1, 1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 2'b10, 11'h000, 56'h3FFFFFFFFFFFFF, 64'h0010000000000000, 1'b1, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 2'b00, 11'h000, 56'h00000000000000, 64'h0000000000000000, 1'b0, 1'b0, 1'b1);
    vecs[6]  = mk(1'b1, 2'b11, 11'h000, 56'h00000000000000, 64'h8000000000000000, 1'b0, 1'b0, 1'b1);
    vecs[7]  = mk(1'b0, 2'b01, 11'h3FF, 56'h40000000000007, 64'h3FF0000000000001, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(1'b0, 2'b00, 11'h3FF, 56'h40000000000003, 64'h3FF0000000000001, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mk(1'b1, 2'b10, 11'h400, 56'h40000000000001, 64'hC000000000000000, 1'b1, 1'b0, 1'b0);
    vecs[10] = mk(1'b1, 2'b11, 11'h400, 56'h40000000000001, 64'hC000000000000001, 1'b1, 1'b0, 1'b0);
    vecs[11] = mk(1'b0, 2'b11, 11'h400, 56'h40000000000001, 64'h4000000000000000, 1'b1, 1'b0, 1'b0);
    vecs[12] = mk(1'b0, 2'b01, 11'h000, 56'h00000000000015, 64'h0000000000000005, 1'b1, 1'b1, 1'b0);
    vecs[13] = mk(1'b0, 2'b00, 11'h000, 56'h00000000000010, 64'h0000000000000004, 1'b0, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 2'b01, 11'h000, 56'h00000000000001, 64'h8000000000000000, 1'b1, 1'b1, 1'b1);
    vecs[15] = mk(1'b0, 2'b11, 11'h000, 56'h00000000000000, 64'h8000000000000000, 1'b0, 1'b0, 1'b1);
    vecs[16] = mk(1'b0, 2'b10, 11'h3FE, 56'h7FFFFFFFFFFFFD, 64'h3FF0000000000000, 1'b1, 1'b0, 1'b0);

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sign = 1'b0;
    diff_2 = '0; exponent_2 = '0; round_mode = 2'b00; cur_exp = '0;

    #3;
    checkBit("reset_out_valid", out_valid, 1'b0);
    checkBit("reset_busy", busy, 1'b0);
    checkOutput("reset_result", result, 64'h0);
    checkBit("reset_inexact", inexact, 1'b0);
    checkBit("reset_underflow", underflow, 1'b0);
    checkBit("reset_zero", zero, 1'b0);
    #9;
    rst = 1'b1;
    #1;
    checkBit("post_reset_in_ready", in_ready, 1'b1);

    // Latency: accept, one empty cycle, then the result.
    @(posedge clk); #1;
    applyStimulus(vecs[0], 0);
    @(negedge clk);
    checkBit("latency_cycle1_out_valid", out_valid, 1'b0);
    @(negedge clk);
    checkBit("latency_cycle2_out_valid", out_valid, 1'b1);
    waitDrain("latency");

    @(posedge clk); #1;
    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], i);
    waitDrain("table_streaming");

    rand_bp = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[NVEC-1-i], NVEC-1-i);
    rand_bp = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    waitDrain("table_backpressure");

    // Backpressure: third beat must stall until the consumer drains.
    @(posedge clk); #1;
    out_ready = 1'b0;
    base = n_out;
    applyStimulus(vecs[2], 2);
    applyStimulus(vecs[9], 9);
    sign = vecs[6].sign; round_mode = vecs[6].mode;
    exponent_2 = vecs[6].exp; diff_2 = vecs[6].diff;
    in_valid = 1'b1;
    @(negedge clk);
    checkBit("bp_in_ready_low", in_ready, 1'b0);
    checkBit("bp_out_valid", out_valid, 1'b1);
    checkOutput("bp_hold_result_1", result, (sb.size() > 0) ? sb[0].res : 64'hX);
    @(negedge clk);
    checkBit("bp_in_ready_still_low", in_ready, 1'b0);
    checkOutput("bp_hold_result_2", result, (sb.size() > 0) ? sb[0].res : 64'hX);
    checkBit("bp_hold_inexact", inexact, (sb.size() > 0) ? sb[0].inx : 1'bX);
    @(posedge clk); #1;
    out_ready = 1'b1;
    applyStimulus(vecs[6], 6);
    waitDrain("bp");
    checkOutput("bp_results_delivered", 64'(n_out - base), 64'd3);

    // Reset mid-stream clears out_valid without a clock edge.
    @(posedge clk); #1;
    out_ready = 1'b0;
    applyStimulus(vecs[1], 1);
    applyStimulus(vecs[3], 3);
    @(negedge clk);
    checkBit("rst_pre_out_valid", out_valid, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    checkBit("rst_async_out_valid", out_valid, 1'b0);
    checkBit("rst_async_busy", busy, 1'b0);
    checkOutput("rst_async_result", result, 64'h0);
    sb.delete();
    @(negedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    checkBit("rst_release_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    applyStimulus(vecs[4], 4);
    waitDrain("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
